// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multicycle MULT/DIV responder: funct codes and FSM states.
// The state encoding is shared with the control unit's MULT/DIV wait states.
package mult_div_unit_pkg;

    localparam logic [5:0] FUNCT_MULT = 6'b011000;
    localparam logic [5:0] FUNCT_DIV  = 6'b011010;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MULT_RUN = 2'd1,
        ST_DIV_RUN  = 2'd2,
        ST_FINISH   = 2'd3
    } md_state_t;

endpackage

// File: rtl/mult_div_unit_div_restoring_step.sv
// One restoring-division step: shift {rem,quot} left, trial-subtract the divisor,
// keep the difference and set the quotient bit when it does not go negative.
module div_restoring_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quot_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quot_out
);

    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] trial;

    always_comb begin
        rem_shift = {rem_in, quot_in[WIDTH-1]};
        trial     = rem_shift - {1'b0, divisor};
        if (trial[WIDTH]) begin
            rem_out  = rem_shift[WIDTH-1:0];
            quot_out = {quot_in[WIDTH-2:0], 1'b0};
        end else begin
            rem_out  = trial[WIDTH-1:0];
            quot_out = {quot_in[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT (radix-2 Booth) / DIV (restoring, on magnitudes) into HI/LO.
// Done pulses WIDTH+1 cycles after an accepted start (1 cycle for divide-by-zero).
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    md_state_t state, state_next;
    logic [CNT_W-1:0] cnt;

    // Booth product register: {upper (WIDTH+1), multiplier (WIDTH), q-1}.
    // The extra upper bit keeps subtracting a -2^(WIDTH-1) multiplicand from overflowing.
    logic [2*WIDTH+1:0] acc;
    logic [2*WIDTH+1:0] acc_next;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH:0]     mcand_ext;
    logic [WIDTH:0]     upper_new;
    logic signed [2*WIDTH+1:0] booth_pre;

    logic [WIDTH-1:0] rem, quot, divisor;
    logic [WIDTH-1:0] rem_next, quot_next;
    logic             sign_a, sign_b;
    logic             is_div, dz;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign a_mag = op_a[WIDTH-1] ? -op_a : op_a;
    assign b_mag = op_b[WIDTH-1] ? -op_b : op_b;
    assign busy  = (state != ST_IDLE);

    always_comb begin
        mcand_ext = {mcand[WIDTH-1], mcand};
        upper_new = acc[2*WIDTH+1:WIDTH+1];
        case (acc[1:0])
            2'b01:   upper_new = acc[2*WIDTH+1:WIDTH+1] + mcand_ext;
            2'b10:   upper_new = acc[2*WIDTH+1:WIDTH+1] - mcand_ext;
            default: upper_new = acc[2*WIDTH+1:WIDTH+1];
        endcase
        booth_pre = {upper_new, acc[WIDTH:0]};
        acc_next  = booth_pre >>> 1;
    end

    div_restoring_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in   (rem),
        .quot_in  (quot),
        .divisor  (divisor),
        .rem_out  (rem_next),
        .quot_out (quot_next)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start_mult)     state_next = ST_MULT_RUN;
                else if (start_div) state_next = (op_b == '0) ? ST_FINISH : ST_DIV_RUN;
            end
            ST_MULT_RUN, ST_DIV_RUN: begin
                if (cnt == LAST_STEP) state_next = ST_FINISH;
            end
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            acc         <= '0;
            mcand       <= '0;
            rem         <= '0;
            quot        <= '0;
            divisor     <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            is_div      <= 1'b0;
            dz          <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (start_mult) begin
                        mcand  <= op_a;
                        acc    <= {{(WIDTH+1){1'b0}}, op_b, 1'b0};
                        is_div <= 1'b0;
                        dz     <= 1'b0;
                    end else if (start_div) begin
                        is_div  <= 1'b1;
                        dz      <= (op_b == '0);
                        sign_a  <= op_a[WIDTH-1];
                        sign_b  <= op_b[WIDTH-1];
                        divisor <= b_mag;
                        rem     <= '0;
                        quot    <= a_mag;
                    end
                end
                ST_MULT_RUN: begin
                    acc <= acc_next;
                    cnt <= (cnt == LAST_STEP) ? '0 : cnt + CNT_W'(1);
                end
                ST_DIV_RUN: begin
                    rem  <= rem_next;
                    quot <= quot_next;
                    cnt  <= (cnt == LAST_STEP) ? '0 : cnt + CNT_W'(1);
                end
                ST_FINISH: begin
                    done <= 1'b1;
                    // Divide-by-zero leaves HI/LO untouched for the exception handler.
                    if (dz) begin
                        div_by_zero <= 1'b1;
                    end else if (is_div) begin
                        lo <= (sign_a ^ sign_b) ? -quot : quot;
                        hi <= sign_a ? -rem : rem;
                    end else begin
                        {hi, lo} <= acc[2*WIDTH:1];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: results, latency, start handling, reset abort.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_mult, start_div;
    logic [31:0] op_a, op_b;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_mult  (start_mult),
        .start_div   (start_div),
        .op_a        (op_a),
        .op_b        (op_b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Issues one start, scrambles operands after the accepting edge, waits for done
    // and checks latency, results and the one-cycle pulse. poke_div > 0 pulses
    // start_div at that wait cycle to confirm starts are ignored while busy.
    task automatic run_op(input string tag, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_dz,
                          input int poke_div);
        int lat;
        @(negedge clk);
        start_mult = m; start_div = d; op_a = a; op_b = b;
        @(negedge clk);
        start_mult = 1'b0; start_div = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'h0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            start_div = (k == poke_div);
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
        start_div = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        check({tag, "_dz"}, 64'(div_by_zero), 64'(exp_dz));
        check({tag, "_idle_at_done"}, 64'(busy), 64'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'({done, div_by_zero}), 64'd0);
    endtask

    initial begin
        int seen_done;
        reset = 1'b1; start_mult = 1'b0; start_div = 1'b0; op_a = '0; op_b = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_state", 64'({busy, done, div_by_zero}), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);

        run_op("mul_7x-3", 1, 0, 32'd7, 32'hFFFF_FFFD, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0);
        run_op("mul_min2", 1, 0, 32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000, 32'h0, 0, 0);
        run_op("div_-7/2", 0, 1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0);
        run_op("div_5/0", 0, 1, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1, 0);
        run_op("div_min/-1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000, 0, 0);
        run_op("div_100/-7", 0, 1, 32'd100, 32'hFFFF_FFF9, 33, 32'd2, 32'hFFFF_FFF2, 0, 0);
        run_op("mul_pokediv", 1, 0, 32'd123, 32'hFFFF_FE38, 33, 32'hFFFF_FFFF, 32'hFFFF_24E8, 0, 5);
        run_op("both_starts", 1, 1, 32'd6, 32'd7, 33, 32'h0, 32'd42, 0, 0);

        // Reset mid-MULT aborts the operation and clears HI/LO.
        @(negedge clk);
        start_mult = 1'b1; op_a = 32'd1000; op_b = 32'd1000;
        @(negedge clk);
        start_mult = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_done", 64'(done), 64'd0);
        seen_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        check("abort_no_done", 64'(seen_done), 64'd0);
        run_op("mul_after_rst", 1, 0, 32'd3, 32'd5, 33, 32'h0, 32'd15, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
